// File: rtl/isp_pkg.sv
// Shared ISP definitions: CFA pattern codes, gain format and channel decode.
package isp_pkg;

    localparam int unsigned BAYER_RGGB = 0;
    localparam int unsigned BAYER_GRBG = 1;
    localparam int unsigned BAYER_GBRG = 2;
    localparam int unsigned BAYER_BGGR = 3;

    localparam int unsigned GAIN_W     = 8;
    localparam int unsigned FRAC_W     = 4;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    // (0,0) is red, (1,1) is blue, the two mixed sites are green
    function automatic chan_e chan_sel(input logic eff_row, input logic eff_col);
        chan_e ch;
        if (!eff_row && !eff_col) begin
            ch = CH_R;
        end else if (eff_row && eff_col) begin
            ch = CH_B;
        end else begin
            ch = CH_G;
        end
        return ch;
    endfunction

endpackage

// File: rtl/isp_bayer_phase.sv
// Bayer phase tracker: sync edge detect, row/column parity and channel select.
module isp_bayer_phase
    import isp_pkg::*;
#(
    parameter int unsigned BAYER = BAYER_RGGB
) (
    input  logic  pclk,
    input  logic  rst_n,
    input  logic  i_href,
    input  logic  i_vsync,
    output chan_e o_chan_c,
    output logic  o_vsync_rise_c
);

    localparam logic [1:0] PAT = 2'(BAYER);

    logic r_href_q;
    logic r_vsync_q;
    logic r_col_p;
    logic r_row_p;
    logic w_href_fall;

    assign o_vsync_rise_c = i_vsync & ~r_vsync_q;
    assign w_href_fall    = r_href_q & ~i_href;

    // previous-cycle copies of the syncs for edge detection
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_href_q  <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_href_q  <= i_href;
            r_vsync_q <= i_vsync;
        end
    end

    // column parity restarts at 0 on every line, toggles per valid pixel
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_p <= 1'b0;
        end else begin
            r_col_p <= i_href & ~r_col_p;
        end
    end

    // row parity advances at line end; frame start clear has priority
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_p <= 1'b0;
        end else if (o_vsync_rise_c) begin
            r_row_p <= 1'b0;
        end else if (w_href_fall) begin
            r_row_p <= ~r_row_p;
        end
    end

    assign o_chan_c = chan_sel(r_row_p ^ PAT[1], r_col_p ^ PAT[0]);

endmodule

// File: rtl/isp_wb.sv
// White-balance gain stage: per-channel 4.4 gain with saturation, 2-cycle latency.
module isp_wb
    import isp_pkg::*;
#(
    parameter int unsigned BITS   = 8,
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 960,
    parameter int unsigned BAYER  = BAYER_RGGB
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic [7:0]      r_gain,
    input  logic [7:0]      g_gain,
    input  logic [7:0]      b_gain,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_raw,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw
);

    localparam int unsigned PROD_W    = BITS + GAIN_W;
    localparam int unsigned PROD_HI_W = PROD_W - FRAC_W;

    // frame geometry is accepted for uniform instantiation; the datapath is size-independent
    if (WIDTH == 0 || HEIGHT == 0) begin : g_no_geometry
    end

    chan_e                 w_chan;
    logic                  w_vsync_rise;
    logic [GAIN_W-1:0]     w_gain;
    logic [GAIN_W-1:0]     r_rsh;
    logic [GAIN_W-1:0]     r_gsh;
    logic [GAIN_W-1:0]     r_bsh;
    logic [PROD_HI_W-1:0]  r_prod_hi;
    logic [BITS-1:0]       r_raw;
    logic                  r_href_d1;
    logic                  r_href_d2;
    logic                  r_vsync_d1;
    logic                  r_vsync_d2;

    isp_bayer_phase #(
        .BAYER (BAYER)
    ) u_phase (
        .pclk           (pclk),
        .rst_n          (rst_n),
        .i_href         (in_href),
        .i_vsync        (in_vsync),
        .o_chan_c       (w_chan),
        .o_vsync_rise_c (w_vsync_rise)
    );

    // shadow gains only move at frame start so a frame never mixes gains
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsh <= GAIN_UNITY;
            r_gsh <= GAIN_UNITY;
            r_bsh <= GAIN_UNITY;
        end else if (w_vsync_rise) begin
            r_rsh <= r_gain;
            r_gsh <= g_gain;
            r_bsh <= b_gain;
        end
    end

    // pick the shadow gain for the current Bayer site
    always_comb begin
        w_gain = r_gsh;
        case (w_chan)
            CH_R:    w_gain = r_rsh;
            CH_B:    w_gain = r_bsh;
            default: w_gain = r_gsh;
        endcase
    end

    // stage 1: product with the fractional bits dropped
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_hi <= '0;
        end else begin
            r_prod_hi <= PROD_HI_W'((PROD_W'(in_raw) * PROD_W'(w_gain)) >> FRAC_W);
        end
    end

    // stage 2: saturate to full scale and blank outside the line
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw <= '0;
        end else if (!r_href_d1) begin
            r_raw <= '0;
        end else if (|r_prod_hi[PROD_HI_W-1:BITS]) begin
            r_raw <= {BITS{1'b1}};
        end else begin
            r_raw <= r_prod_hi[BITS-1:0];
        end
    end

    // sync delay matching the two datapath stages
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_href_d1  <= 1'b0;
            r_href_d2  <= 1'b0;
            r_vsync_d1 <= 1'b0;
            r_vsync_d2 <= 1'b0;
        end else begin
            r_href_d1  <= in_href;
            r_href_d2  <= r_href_d1;
            r_vsync_d1 <= in_vsync;
            r_vsync_d2 <= r_vsync_d1;
        end
    end

    assign out_href  = r_href_d2;
    assign out_vsync = r_vsync_d2;
    assign out_raw   = r_raw;

endmodule

// File: tb/tb_isp_wb.sv
// Bench for isp_wb: RGGB and BGGR instances, vector table, directed corners, random frames.
module tb_isp_wb;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic [7:0] r_gain, g_gain, b_gain;
    logic       in_href, in_vsync;
    logic [7:0] in_raw;
    logic       o_href0, o_vs0, o_href3, o_vs3;
    logic [7:0] o_raw0, o_raw3;

    always #5 pclk = ~pclk;

    isp_wb #(.BITS(8), .WIDTH(1280), .HEIGHT(960), .BAYER(0)) u_dut0 (
        .pclk(pclk), .rst_n(rst_n), .r_gain(r_gain), .g_gain(g_gain), .b_gain(b_gain),
        .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(o_href0), .out_vsync(o_vs0), .out_raw(o_raw0));

    isp_wb #(.BITS(8), .WIDTH(1280), .HEIGHT(960), .BAYER(3)) u_dut3 (
        .pclk(pclk), .rst_n(rst_n), .r_gain(r_gain), .g_gain(g_gain), .b_gain(b_gain),
        .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
        .out_href(o_href3), .out_vsync(o_vs3), .out_raw(o_raw3));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wb(input int raw, input int gain);
        int p;
        p = (raw * gain) / 16;
        return (p > 255) ? 255 : p;
    endfunction

    // line = lines completed since frame start, pix = pixels so far in this line
    function automatic int site_gain(input int pat, input int line, input int pix,
                                     input int rs, input int gs, input int bs);
        int er, ec;
        er = (line % 2) ^ ((pat / 2) % 2);
        ec = (pix % 2) ^ (pat % 2);
        if (er == 0 && ec == 0) return rs;
        if (er == 1 && ec == 1) return bs;
        return gs;
    endfunction

    int m_line, m_pix, m_rs, m_gs, m_bs;
    bit m_prev_h, m_prev_v;
    int m_p1_h, m_p1_v, m_p1_r0, m_p1_r3;
    int m_p2_h, m_p2_v, m_p2_r0, m_p2_r3;

    always @(posedge pclk) begin
        if (!rst_n) begin
            m_line = 0; m_pix = 0; m_rs = 16; m_gs = 16; m_bs = 16;
            m_prev_h = 0; m_prev_v = 0;
            m_p1_h = 0; m_p1_v = 0; m_p1_r0 = 0; m_p1_r3 = 0;
            m_p2_h = 0; m_p2_v = 0; m_p2_r0 = 0; m_p2_r3 = 0;
        end else begin
            m_p2_h = m_p1_h; m_p2_v = m_p1_v; m_p2_r0 = m_p1_r0; m_p2_r3 = m_p1_r3;
            m_p1_h = int'(in_href);
            m_p1_v = int'(in_vsync);
            m_p1_r0 = in_href ? wb(int'(in_raw), site_gain(0, m_line, m_pix, m_rs, m_gs, m_bs)) : 0;
            m_p1_r3 = in_href ? wb(int'(in_raw), site_gain(3, m_line, m_pix, m_rs, m_gs, m_bs)) : 0;
            m_pix = in_href ? m_pix + 1 : 0;
            if (in_vsync && !m_prev_v) begin
                m_line = 0;
                m_rs = int'(r_gain); m_gs = int'(g_gain); m_bs = int'(b_gain);
            end else if (m_prev_h && !in_href) begin
                m_line = m_line + 1;
            end
            m_prev_h = in_href;
            m_prev_v = in_vsync;
        end
    end

    // scoreboard: every cycle, both instances against the model
    always @(negedge pclk) begin
        if (!rst_n) begin
            chk("sb_rst_href0", {31'd0, o_href0}, 0);
            chk("sb_rst_raw0",  {24'd0, o_raw0},  0);
            chk("sb_rst_raw3",  {24'd0, o_raw3},  0);
        end else begin
            chk("sb_href0",  {31'd0, o_href0}, m_p2_h);
            chk("sb_vsync0", {31'd0, o_vs0},   m_p2_v);
            chk("sb_raw0",   {24'd0, o_raw0},  m_p2_r0);
            chk("sb_href3",  {31'd0, o_href3}, m_p2_h);
            chk("sb_vsync3", {31'd0, o_vs3},   m_p2_v);
            chk("sb_raw3",   {24'd0, o_raw3},  m_p2_r3);
        end
    end

    // capture of valid output pixels for the directed sequences
    int cap0[$];
    int cap3[$];
    always @(negedge pclk) begin
        if (rst_n && o_href0) cap0.push_back(int'(o_raw0));
        if (rst_n && o_href3) cap3.push_back(int'(o_raw3));
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] rg, gg, bg;
        logic       href, vs;
        logic [7:0] raw;
        logic [7:0] e0, e3;
    } vec_t;
    vec_t tbl[$];

    function automatic void push(input logic [7:0] rg, gg, bg, input logic h, v,
                                 input logic [7:0] raw, e0, e3);
        vec_t t;
        t.rg = rg; t.gg = gg; t.bg = bg; t.href = h; t.vs = v;
        t.raw = raw; t.e0 = e0; t.e3 = e3;
        tbl.push_back(t);
    endfunction

    function automatic void push_frame_start(input logic [7:0] rg, gg, bg);
        push(rg, gg, bg, 0, 1, 8'd0, 8'd0, 8'd0);
        push(rg, gg, bg, 0, 1, 8'd0, 8'd0, 8'd0);
        push(rg, gg, bg, 0, 0, 8'd0, 8'd0, 8'd0);
    endfunction

    // four-pixel line, bytes packed first-pixel-high, then a two-cycle gap
    function automatic void push_line(input logic [7:0] rg, gg, bg,
                                      input logic [31:0] raws, exp0, exp3);
        for (int k = 0; k < 4; k++) begin
            push(rg, gg, bg, 1, 0, raws[31-8*k -: 8], exp0[31-8*k -: 8], exp3[31-8*k -: 8]);
        end
        push(rg, gg, bg, 0, 0, 8'd0, 8'd0, 8'd0);
        push(rg, gg, bg, 0, 0, 8'd0, 8'd0, 8'd0);
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drv(input logic h, input logic v, input logic [7:0] raw);
        in_href = h; in_vsync = v; in_raw = raw;
        tick();
    endtask

    task automatic frame_start();
        drv(0, 1, 8'd0);
        drv(0, 1, 8'd0);
        drv(0, 0, 8'd0);
    endtask

    task automatic send_line(input int n, input logic [7:0] raw);
        for (int k = 0; k < n; k++) drv(1, 0, raw);
        drv(0, 0, 8'd0);
        drv(0, 0, 8'd0);
    endtask

    task automatic expect_caps(input string name, input logic [31:0] exp0, input int n);
        chk({name, "_count"}, cap0.size(), n);
        for (int k = 0; k < n && k < cap0.size(); k++) begin
            chk($sformatf("%s_px%0d", name, k), cap0[k], {24'd0, exp0[31-8*(k%4) -: 8]});
        end
    endtask

    initial begin
        rst_n = 1'b0; in_href = 0; in_vsync = 0; in_raw = 0;
        r_gain = 8'h10; g_gain = 8'h10; b_gain = 8'h10;
        tick(); tick(); tick();
        chk("reset_href",  {31'd0, o_href0}, 0);
        chk("reset_vsync", {31'd0, o_vs0},   0);
        chk("reset_raw",   {24'd0, o_raw0},  0);
        rst_n = 1'b1;
        tick();

        // unity gains, flat 100
        push_frame_start(8'h10, 8'h10, 8'h10);
        push_line(8'h10, 8'h10, 8'h10, {4{8'd100}}, {4{8'd100}}, {4{8'd100}});
        push_line(8'h10, 8'h10, 8'h10, {4{8'd100}}, {4{8'd100}}, {4{8'd100}});
        // per-channel gains, flat 64
        push_frame_start(8'h20, 8'h10, 8'h08);
        push_line(8'h20, 8'h10, 8'h08, {4{8'd64}}, {8'd128, 8'd64, 8'd128, 8'd64}, {8'd32, 8'd64, 8'd32, 8'd64});
        push_line(8'h20, 8'h10, 8'h08, {4{8'd64}}, {8'd64, 8'd32, 8'd64, 8'd32}, {8'd64, 8'd128, 8'd64, 8'd128});
        // maximum gain everywhere
        push_frame_start(8'hFF, 8'hFF, 8'hFF);
        push_line(8'hFF, 8'hFF, 8'hFF, {8'd255, 8'd16, 8'd17, 8'd1}, {8'd255, 8'd255, 8'd255, 8'd15}, {8'd255, 8'd255, 8'd255, 8'd15});
        push_line(8'hFF, 8'hFF, 8'hFF, {8'd0, 8'd2, 8'd3, 8'd32}, {8'd0, 8'd31, 8'd47, 8'd255}, {8'd0, 8'd31, 8'd47, 8'd255});
        // zero gain
        push_frame_start(8'h00, 8'h00, 8'h00);
        push_line(8'h00, 8'h00, 8'h00, {8'd200, 8'd1, 8'd255, 8'd9}, 32'd0, 32'd0);
        push_line(8'h00, 8'h00, 8'h00, {8'd200, 8'd1, 8'd255, 8'd9}, 32'd0, 32'd0);
        // green-only saturation
        push_frame_start(8'h10, 8'hFF, 8'h10);
        push_line(8'h10, 8'hFF, 8'h10, {8'd50, 8'd255, 8'd50, 8'd16}, {8'd50, 8'd255, 8'd50, 8'd255}, {8'd50, 8'd255, 8'd50, 8'd255});
        push_line(8'h10, 8'hFF, 8'h10, {8'd17, 8'd50, 8'd17, 8'd50}, {8'd255, 8'd50, 8'd255, 8'd50}, {8'd255, 8'd50, 8'd255, 8'd50});
        push(8'h10, 8'h10, 8'h10, 0, 0, 8'd0, 8'd0, 8'd0);
        push(8'h10, 8'h10, 8'h10, 0, 0, 8'd0, 8'd0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            r_gain = tbl[i].rg; g_gain = tbl[i].gg; b_gain = tbl[i].bg;
            in_href = tbl[i].href; in_vsync = tbl[i].vs; in_raw = tbl[i].raw;
            tick();
            if (i >= 1) begin
                chk($sformatf("tbl%0d_href", i - 1),  {31'd0, o_href0}, {31'd0, tbl[i-1].href});
                chk($sformatf("tbl%0d_vsync", i - 1), {31'd0, o_vs3},   {31'd0, tbl[i-1].vs});
                chk($sformatf("tbl%0d_raw0", i - 1),  {24'd0, o_raw0},  {24'd0, tbl[i-1].e0});
                chk($sformatf("tbl%0d_raw3", i - 1),  {24'd0, o_raw3},  {24'd0, tbl[i-1].e3});
            end
        end

        // mid-frame gain write must not tear the frame
        r_gain = 8'h10; g_gain = 8'h10; b_gain = 8'h10;
        frame_start();
        cap0.delete(); cap3.delete();
        send_line(4, 8'd10);
        r_gain = 8'h40;
        send_line(4, 8'd10);
        send_line(4, 8'd10);
        drv(0, 0, 8'd0);
        expect_caps("tear_hold", {4{8'd10}}, 12);
        chk("tear_hold_count3", cap3.size(), 12);
        frame_start();
        cap0.delete();
        send_line(4, 8'd10);
        drv(0, 0, 8'd0);
        expect_caps("tear_new", {8'd40, 8'd10, 8'd40, 8'd10}, 4);

        // reset in the middle of a line with a 4x red gain latched
        frame_start();
        drv(1, 0, 8'd10);
        drv(1, 0, 8'd10);
        drv(1, 0, 8'd10);
        chk("pre_reset_href", {31'd0, o_href0}, 1);
        rst_n = 1'b0; in_href = 0;
        #1;
        chk("mid_reset_href", {31'd0, o_href0}, 0);
        chk("mid_reset_raw",  {24'd0, o_raw0},  0);
        tick(); tick();
        rst_n = 1'b1;
        cap0.delete();
        send_line(4, 8'd10);
        drv(0, 0, 8'd0);
        expect_caps("post_reset", {4{8'd10}}, 4);

        // random frames: odd lengths, syncs overlapping, mid-frame gain writes
        for (int f = 0; f < 30; f++) begin
            r_gain = 8'($urandom_range(0, 255));
            g_gain = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom_range(0, 255));
            b_gain = 8'($urandom_range(0, 255));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                drv(($urandom_range(0, 3) == 0), 1, 8'($urandom));
            end
            drv(0, 0, 8'($urandom));
            for (int l = 0; l < int'($urandom_range(1, 5)); l++) begin
                if ($urandom_range(0, 3) == 0) r_gain = 8'($urandom);
                for (int p = 0; p < int'($urandom_range(1, 9)); p++) drv(1, 0, 8'($urandom));
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) drv(0, 0, 8'($urandom));
            end
        end
        drv(0, 0, 8'd0);
        drv(0, 0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isp_wb.md
Name: isp_wb

Overview:
- Per-channel white-balance gain stage on the raw Bayer stream, directly downstream of the digital-gain stage.
- Consumes dgain's out_href, out_vsync and out_raw.
- Tracks the Bayer phase with row and column parity counters and multiplies each pixel by the R, G or B gain (4.4 fixed point), with saturation.
- Gains are shadow-latched once per frame so mid-frame register writes never tear an image.

Parameters:
- BITS, 8: raw pixel width.
- WIDTH, 1280: frame width; not used by the logic; kept for uniform ISP instantiation.
- HEIGHT, 960: frame height; not used by the logic; kept for uniform ISP instantiation.
- BAYER, 0: CFA pattern. 0 = RGGB, 1 = GRBG, 2 = GBRG, 3 = BGGR.

Ports:
- pclk  in  1  pixel clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r_gain  in  8  red gain, 4.4 format (8'h10 = 1.0).
- g_gain  in  8  green gain, 4.4 format (applies to both Gr and Gb).
- b_gain  in  8  blue gain, 4.4 format.
- in_href  in  1  line valid.
- in_vsync  in  1  frame sync, active high.
- in_raw  in  BITS  raw pixel.
- out_href  out  1  line valid, delayed 2 cycles.
- out_vsync  out  1  frame sync, delayed 2 cycles.
- out_raw  out  BITS  white-balanced pixel; 0 whenever out_href = 0.

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low on rst_n.
- Reset state:
  - All pipeline registers = 0; out_href = 0, out_vsync = 0, out_raw = 0.
  - Parity counters = 0.
  - Shadow gains r_sh, g_sh and b_sh = 8'h10 (unity).
- Edge detection: a registered copy of in_href and in_vsync provides the rising and falling edges.
- Shadow gains: on an in_vsync rising edge (prev 0, now 1), r_sh/g_sh/b_sh load r_gain/g_gain/b_gain. Otherwise they hold. Gain inputs have no effect mid-frame.
- Column parity (col_p):
  - Forced to 0 while in_href = 0.
  - While in_href = 1, the current pixel uses col_p; col_p then toggles.
- Row parity (row_p):
  - Toggles on an in_href falling edge.
  - Cleared to 0 on an in_vsync rising edge.
  - If both occur in the same cycle, the clear wins.
- Channel select:
  - eff_row = row_p ^ BAYER[1]; eff_col = col_p ^ BAYER[0].
  - (0,0) selects R; (1,1) selects B; otherwise G.
- Pipeline stage 1: prod = in_raw * selected shadow gain. prod is BITS+8 bits wide, registered unconditionally.
- Pipeline stage 2: if prod[BITS+7:4] > all-ones, the result saturates to {BITS{1'b1}}; otherwise the result is prod[BITS+3:4]. The result is registered.
- Sync delay: href and vsync pass through a 2-deep shift register. Latency is exactly 2 cycles for data and sync.
- Output: out_raw = out_href ? stage-2 data : 0.
- Boundary conditions:
  - Gain 8'h00 gives output 0.
  - Gain 8'hFF gives 15.9375x; with in_raw = 1 the output is 15.
  - Odd-length lines: col_p still restarts at 0 on the next line.
  - Lines longer than WIDTH: parity keeps toggling; no error.
  - in_href asserted during in_vsync = 1: processed normally.
  - Reset mid-frame: gains return to unity and parity to 0. The first line after release is treated as row 0.

Decomposition:
- Shared package isp_pkg:
  - BAYER_RGGB / GRBG / GBRG / BGGR constants.
  - GAIN_UNITY = 8'h10.
  - The 4.4 fraction-width constant (4).
- Sub-module isp_bayer_phase holds the edge detect, row/col parity counters and channel-select output (2-bit: R, G, B). It is reused by the later demosaic and AWB-statistics stages.

Test Plan:
- Unity gains, RGGB, 4x2 frame with in_raw = 100 on every pixel: every out_raw = 100, appearing 2 cycles after in_href; out_href/out_vsync equal the inputs delayed 2 cycles.
- RGGB, r_gain = 8'h20, g_gain = 8'h10, b_gain = 8'h08 latched by a vsync rise, in_raw = 64 on every pixel:
  - Line 0 outputs 128, 64, 128, 64.
  - Line 1 outputs 64, 32, 64, 32.
- Same stimulus with BAYER = 3 (BGGR):
  - Line 0 outputs 32, 64, 32, 64.
  - Line 1 outputs 64, 128, 64, 128.
- Saturation: g_gain = 8'hFF, in_raw = 255 on a G site gives 255. in_raw = 16 on a G site gives 255 (16 x 255 >> 4 = 255, not above all-ones, so unsaturated). in_raw = 17 on a G site gives 255, saturated.
- Gain tearing: change r_gain from 8'h10 to 8'h40 mid-frame with in_raw = 10 on R sites. The rest of the frame's R outputs stay 10; after the next vsync rise they become 40.
- Reset asserted mid-line with r_gain = 8'h40 already latched:
  - Outputs go to 0 immediately.
  - After release, with no vsync rise, an R pixel of 10 outputs 10 (unity gain), and the first line decodes as row 0.
